// File: rtl/stage_ex_muldiv.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO: 32-step shift-add multiply, 32-step restoring divide.
// Define STAGE_EX_MULDIV_FAST_MUL_EN to make MULT/MULTU single-cycle combinational products.
module stage_ex_muldiv (
    input  logic        clock,
    input  logic        reset_0,
    input  logic        md_valid_ex,
    input  logic [2:0]  md_op_ex,
    input  logic        hold_ex,
    input  logic [31:0] a_ex,
    input  logic [31:0] b_ex,
    output logic        stall_ex,
    output logic        busy,
    output logic [31:0] md_result_ex,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        dz_ex
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [2:0] OP_MFLO  = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opd_b;
    logic [31:0] a_orig;
    logic        is_div, neg_res, neg_rem, div_zero;

    function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn_op);
        return (sgn_op && v < 0) ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    logic        accept, sgn_op, start_mul, start_div, fast_wr;
    logic [31:0] a_mag, b_mag;

    assign accept = md_valid_ex & ~hold_ex & ~busy;
    assign sgn_op = (md_op_ex == OP_MULT) | (md_op_ex == OP_DIV);
    assign a_mag  = mag32($signed(a_ex), sgn_op);
    assign b_mag  = mag32($signed(b_ex), sgn_op);

    assign start_div = accept & ((md_op_ex == OP_DIV) | (md_op_ex == OP_DIVU));
`ifdef STAGE_EX_MULDIV_FAST_MUL_EN
    logic signed [63:0] fast_prod;
    assign fast_prod = (md_op_ex == OP_MULT)
                     ? $signed({{32{a_ex[31]}}, a_ex}) * $signed({{32{b_ex[31]}}, b_ex})
                     : $signed({32'd0, a_ex} * {32'd0, b_ex});
    assign start_mul = 1'b0;
    assign fast_wr   = accept & ((md_op_ex == OP_MULT) | (md_op_ex == OP_MULTU));
`else
    assign start_mul = accept & ((md_op_ex == OP_MULT) | (md_op_ex == OP_MULTU));
    assign fast_wr   = 1'b0;
`endif

    assign stall_ex = md_valid_ex & busy;

    always_comb begin
        md_result_ex = 32'd0;
        if (md_valid_ex && md_op_ex == OP_MFHI) md_result_ex = hi_out;
        if (md_valid_ex && md_op_ex == OP_MFLO) md_result_ex = lo_out;
    end

    // Single iteration of each datapath: partial product enters the top, multiplier shifts out the bottom
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_sh;
    logic [33:0] div_diff;
    logic [63:0] div_next;

    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd_b} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};
    assign div_sh   = {acc[63:32], acc[31]};
    assign div_diff = {1'b0, div_sh} - {2'b00, opd_b};
    assign div_next = div_diff[33] ? {div_sh[31:0], acc[30:0], 1'b0}
                                   : {div_diff[31:0], acc[30:0], 1'b1};

    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;
    assign prod_fix = cond_neg64(acc, neg_res);
    assign quot_fix = cond_neg32(acc[31:0], neg_res);
    assign rem_fix  = cond_neg32(acc[63:32], neg_rem);

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_mul)      state_nxt = MUL;
                else if (start_div) state_nxt = DIV;
            end
            MUL:     if (cnt == 5'd0) state_nxt = FIX;
            DIV:     if (cnt == 5'd0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            busy     <= 1'b0;
            cnt      <= 5'd0;
            acc      <= 64'd0;
            opd_b    <= 32'd0;
            a_orig   <= 32'd0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= 32'd0;
            lo_out   <= 32'd0;
            dz_ex    <= 1'b0;
        end else begin
            dz_ex <= (state == FIX) & is_div & div_zero;
            if (accept && md_op_ex == OP_MTHI) hi_out <= a_ex;
            if (accept && md_op_ex == OP_MTLO) lo_out <= a_ex;
`ifdef STAGE_EX_MULDIV_FAST_MUL_EN
            if (fast_wr) begin
                hi_out <= fast_prod[63:32];
                lo_out <= fast_prod[31:0];
            end
`endif
            if (start_mul || start_div) begin
                busy     <= 1'b1;
                cnt      <= 5'd31;
                is_div   <= start_div;
                a_orig   <= a_ex;
                div_zero <= start_div & (b_ex == 32'd0);
                neg_res  <= sgn_op & (a_ex[31] ^ b_ex[31]);
                neg_rem  <= sgn_op & a_ex[31];
                acc      <= {32'd0, start_div ? a_mag : b_mag};
                opd_b    <= start_div ? b_mag : a_mag;
            end
            if (state == MUL) begin
                acc <= mul_next;
                cnt <= cnt - 5'd1;
            end
            if (state == DIV) begin
                acc <= div_next;
                cnt <= cnt - 5'd1;
            end
            // Completion: sign fixup and architectural write-back
            if (state == FIX) begin
                busy <= 1'b0;
                if (!is_div) begin
                    hi_out <= prod_fix[63:32];
                    lo_out <= prod_fix[31:0];
                end else if (div_zero) begin
                    hi_out <= a_orig;
                    lo_out <= 32'hFFFF_FFFF;
                end else begin
                    hi_out <= rem_fix;
                    lo_out <= quot_fix;
                end
            end
        end
    end

    logic unused_fast;
    assign unused_fast = fast_wr;

endmodule

// File: tb/tb_stage_ex_muldiv.sv
// Scoreboard bench for stage_ex_muldiv: reference model in plain 64-bit arithmetic, randomized ops plus directed corners.
module tb_stage_ex_muldiv;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [2:0] OP_MFLO  = 3'b111;

`ifdef STAGE_EX_MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_0 = 1'b0;
    logic        md_valid_ex = 1'b0;
    logic [2:0]  md_op_ex = 3'd0;
    logic        hold_ex = 1'b0;
    logic [31:0] a_ex = 32'd0;
    logic [31:0] b_ex = 32'd0;
    logic        stall_ex, busy, dz_ex;
    logic [31:0] md_result_ex, hi_out, lo_out;

    stage_ex_muldiv dut (
        .clock(clock), .reset_0(reset_0), .md_valid_ex(md_valid_ex), .md_op_ex(md_op_ex),
        .hold_ex(hold_ex), .a_ex(a_ex), .b_ex(b_ex), .stall_ex(stall_ex), .busy(busy),
        .md_result_ex(md_result_ex), .hi_out(hi_out), .lo_out(lo_out), .dz_ex(dz_ex)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_mf;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] val;
        bit          dz;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Architectural meaning of each op, straight from MIPS semantics
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output bit dz);
        longint p, q, r;
        dz = 1'b0;
        p = 0; q = 0; r = 0;
        case (op)
            OP_MULT:  p = longint'($signed(a)) * longint'($signed(b));
            OP_MULTU: p = longint'({32'd0, a}) * longint'({32'd0, b});
            OP_DIV: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
            end
            default: if (b != 0) begin
                q = longint'({32'd0, a / b});
                r = longint'({32'd0, a % b});
            end
        endcase
        if (op == OP_MULT || op == OP_MULTU) begin
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else begin
            hi = r[31:0];
            lo = q[31:0];
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold_first, output int waits);
        exp_t e;
        e = '{is_mf: 1'b0, hi: 32'd0, lo: 32'd0, val: 32'd0, dz: 1'b0};
        case (op)
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            OP_MFHI, OP_MFLO: begin
                e.is_mf = 1'b1;
                e.val = (op == OP_MFHI) ? m_hi : m_lo;
                sb.push_back(e);
            end
            default: begin
                model(op, a, b, e.hi, e.lo, e.dz);
                m_hi = e.hi;
                m_lo = e.lo;
                if (!(FAST && op[1] == 1'b0)) sb.push_back(e);
            end
        endcase
        @(negedge clock);
        md_valid_ex = 1'b1;
        md_op_ex = op;
        a_ex = a;
        b_ex = b;
        hold_ex = hold_first;
        waits = 0;
        forever begin
            if (!busy && !hold_ex) break;
            waits++;
            if (waits > 200) begin
                $display("FAIL accept_timeout actual=%0d required<=200", waits);
                $fatal(1, "accept timeout");
            end
            @(negedge clock);
            hold_ex = 1'b0;
        end
        @(posedge clock);
        #1 md_valid_ex = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL idle_timeout actual=%0d required<300", n);
        end
        @(negedge clock);
    endtask

    // Monitor: retires completions at the busy falling edge and MF reads at their acceptance cycle
    initial begin
        bit busy_prev, dz_next;
        int blen;
        exp_t e;
        busy_prev = 1'b0;
        dz_next = 1'b0;
        blen = 0;
        forever begin
            @(negedge clock);
            #1;
            if (!reset_0) begin
                busy_prev = 1'b0;
                dz_next = 1'b0;
                blen = 0;
                continue;
            end
            if (dz_next) chk("dz_pulse_end", {31'd0, dz_ex}, 32'd0);
            dz_next = 1'b0;
            if (busy) blen++;
            if (busy_prev && !busy) begin
                if (sb.size() == 0 || sb[0].is_mf) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion actual=done required=none_pending");
                end else begin
                    e = sb.pop_front();
                    chk("done_hi", hi_out, e.hi);
                    chk("done_lo", lo_out, e.lo);
                    chk("done_dz", {31'd0, dz_ex}, {31'd0, e.dz});
                    chk("busy_len", blen, 33);
                    dz_next = e.dz;
                end
                blen = 0;
            end else if (!busy) begin
                chk("dz_quiet", {31'd0, dz_ex}, 32'd0);
            end
            if (md_valid_ex && !hold_ex && !busy && md_op_ex[2:1] == 2'b11) begin
                if (sb.size() == 0 || !sb[0].is_mf) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mf actual=read required=queued_mf");
                end else begin
                    e = sb.pop_front();
                    chk("mf_result", md_result_ex, e.val);
                    chk("mf_stall", {31'd0, stall_ex}, 32'd0);
                end
            end
            busy_prev = busy;
        end
    end

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int w;
        int exp_w;
        exp_w = FAST ? 0 : 33;

        // Reset state, with an MFHI presented so the read path is exercised
        md_valid_ex = 1'b1;
        md_op_ex = OP_MFHI;
        #12;
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dz", {31'd0, dz_ex}, 32'd0);
        chk("rst_stall", {31'd0, stall_ex}, 32'd0);
        chk("rst_result", md_result_ex, 32'd0);
        md_valid_ex = 1'b0;
        @(negedge clock);
        reset_0 = 1'b1;

        // Directed corners
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, w);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0, w);
        chk("multu_mfhi_stall", w, exp_w);
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0, w);
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, w);
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, w);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, w);
        issue(OP_DIVU, 32'd7, 32'd2, 1'b0, w);
        issue(OP_DIVU, 32'd5, 32'd0, 1'b0, w);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, w);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0, w);
        wait_idle();
        chk("dz_final_hi", hi_out, 32'hFFFF_FFF9);
        chk("dz_final_lo", lo_out, 32'hFFFF_FFFF);

        // Dependent MFLO right behind MULTU
        issue(OP_MULTU, 32'd6, 32'd7, 1'b0, w);
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0, w);
        chk("mflo_dep_stall", w, exp_w);
        chk("mflo_42_lo", lo_out, 32'd42);

        // MTLO while a divide is in flight must land after it
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, w);
        issue(OP_MTLO, 32'h0000_ABCD, 32'd0, 1'b0, w);
        chk("mtlo_busy_stall", w, 33);
        issue(OP_MFLO, 32'd0, 32'd0, 1'b0, w);
        issue(OP_MFHI, 32'd0, 32'd0, 1'b0, w);
        wait_idle();

        // hold_ex suppresses acceptance
        @(negedge clock);
        md_valid_ex = 1'b1;
        md_op_ex = OP_MTHI;
        a_ex = 32'hDEAD_BEEF;
        hold_ex = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("hold_no_accept", hi_out, m_hi);
            chk("hold_busy", {31'd0, busy}, 32'd0);
        end
        md_valid_ex = 1'b0;
        hold_ex = 1'b0;

        // Asynchronous reset mid-divide
        wait_idle();
        issue(OP_DIV, 32'hFFFF_FF00, 32'd3, 1'b0, w);
        repeat (10) @(posedge clock);
        #2 reset_0 = 1'b0;
        #1;
        chk("midrst_hi", hi_out, 32'd0);
        chk("midrst_lo", lo_out, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clock);
        #3 reset_0 = 1'b1;
        issue(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0, w);
        chk("mthi_after_rst", hi_out, 32'h1234_5678);
        chk("mthi_no_stall", w, 0);

        // Randomized op stream with occasional hold on first presentation
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            issue(op, rnd_opnd(), rnd_opnd(), ($urandom_range(0, 3) == 0), w);
        end
        wait_idle();
        chk("final_hi", hi_out, m_hi);
        chk("final_lo", lo_out, m_lo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_ex_muldiv.md
# stage_ex_muldiv

Multi-cycle multiply/divide controller beside the EX-stage ALU of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from EX and sequences an iterative shift-add multiplier or restoring divider over the HI/LO registers. It stalls EX while an operation is in flight, so the single-cycle ALU path carries no multiply or divide.

## Interface
No parameters; all widths are fixed at 32-bit MIPS.
- clock  input  1  pipeline clock, rising edge
- reset_0  input  1  asynchronous, active-low reset
- md_valid_ex  input  1  EX holds a mul/div-class instruction
- md_op_ex  input  3  opcode: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
- hold_ex  input  1  EX frozen by another stall source; no acceptance
- a_ex  input  32  rs operand (multiplicand / dividend / MTHI-MTLO data)
- b_ex  input  32  rt operand (multiplier / divisor)
- stall_ex  output  1  combinational: md_valid_ex & busy
- busy  output  1  registered; operation in flight
- md_result_ex  output  32  combinational: HI for MFHI, LO for MFLO, else 0
- hi_out, lo_out  output  32 each  architectural HI/LO registers
- dz_ex  output  1  one-cycle pulse on completion of a divide by zero

## Operation
- Accept when md_valid_ex & !hold_ex & !busy, sampled at a rising edge.
- MTHI/MTLO: write a_ex to HI/LO on the accept edge; busy stays 0.
- MFHI/MFLO: md_result_ex is driven combinationally from the current HI/LO; no state change.
- MULT/MULTU/DIV/DIVU use a state machine with states IDLE, MUL, DIV and FIX, plus a 5-bit counter.
- Accept edge:
  - latch operand magnitudes (signed ops only) and the result sign;
  - load the 64-bit accumulator and set counter = 31;
  - enter MUL or DIV; busy <= 1.
- MUL: one shift-add step per cycle.
- DIV: one restoring subtract-shift step per cycle.
- Both MUL and DIV decrement the counter each cycle and go to FIX after the step where counter = 0, i.e. 32 steps.
- FIX (one cycle), then IDLE with busy <= 0:
  - signed MULT: negate the 64-bit product when the operand signs differ;
  - signed DIV: quotient negative when operand signs differ; remainder takes the dividend's sign;
  - unsigned ops: no change;
  - write HI = product[63:32] / remainder and LO = product[31:0] / quotient.
- Divide by zero:
  - LO = 0xFFFFFFFF and HI = a_ex as originally presented;
  - the sign fixup is skipped for signed DIV;
  - dz_ex pulses high in the cycle after the FIX edge.
- While busy, every md-class op stalls, including MFHI/MFLO/MTHI/MTLO; no result forwarding.
- Arithmetic is modulo 2^64 for the product and exact 32-bit for quotient/remainder. Signed negation of 0x80000000 yields magnitude 0x80000000 (unsigned), which is correct.

## Timing
- Reset (reset_0 low, asynchronous):
  - hi_out = lo_out = 0, busy = 0, state IDLE, counter = 0, dz_ex = 0;
  - stall_ex = 0 and md_result_ex = 0 unless md_valid_ex selects HI/LO;
  - an in-flight op is discarded.
- Mul/div latency:
  - accept edge E0, steps on edges E1..E32, FIX write at E33;
  - busy is high for 33 cycles;
  - a dependent MFHI/MFLO held in EX sees stall_ex fall and the new HI/LO in the cycle after E33.
- A new mul/div can be accepted at the edge after busy falls (E34); no back-to-back overlap.
- hold_ex asserted while busy has no effect on sequencing. hold_ex suppresses acceptance only.
- MTHI/MTLO and MFHI/MFLO while idle complete with zero stall cycles.

## Configuration
- STAGE_EX_MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU compute the full 64-bit signed/unsigned product combinationally;
  - the product is written to HI/LO on the accept edge;
  - busy stays 0, and the MUL state is unused for these ops;
  - DIV/DIVU are unchanged.
- Macro undefined: iterative 33-cycle multiply as in Operation.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, busy high 33 cycles (0 cycles with STAGE_EX_MULDIV_FAST_MUL_EN).
- MULT a=0xFFFFFFFD (-3) b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7 b=2 -> LO=3, HI=1.
- DIVU a=5 b=0 -> LO=0xFFFFFFFF, HI=5, dz_ex high exactly one cycle. DIV a=0xFFFFFFF9 b=0 -> LO=0xFFFFFFFF, HI=0xFFFFFFF9.
- MULTU 6x7 accepted, MFLO presented the next cycle -> stall_ex high through E33, then md_result_ex=42 with stall_ex=0. MTLO presented while busy -> stalled and written only after completion.
- Reset pulsed low at cycle 10 of a DIV -> HI/LO=0 and busy=0 immediately. After release, MTHI 0x12345678 -> hi_out=0x12345678 next cycle. hold_ex=1 with md_valid_ex=1 -> no acceptance.
